croc_soc_ctrl_regs: RTL and testbench

SoC control register block of the croc SoC, reached over the SoC's OBI subordinate bus. It holds the core boot address, the software fetch-enable bit and the core status/exit-code word. It drives the core's boot address and fetch enable, plus the chip-level status pin. The debug module (via system-bus access) and the core use this block to start execution and to signal end-of-computation.

---
 rtl/croc_soc_ctrl_regs_if.sv | 35 +++
 rtl/croc_soc_ctrl_regs.sv | 130 +++++++++++++
 tb/tb_croc_soc_ctrl_regs.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/croc_soc_ctrl_regs_if.sv
// OBI subordinate bus bundle for the croc SoC control register block.
//
// Signals (names keep the subordinate's point of view):
//   req_i / we_i / be_i / addr_i / wdata_i / aid_i : request phase, master -> slave
//   gnt_o                                          : grant, slave -> master
//   rvalid_o / rdata_o / err_o / rid_o             : response phase, slave -> master
//
// Modports:
//   master : drives the request, observes grant and response
//   slave  : observes the request, drives grant and response
interface croc_soc_ctrl_regs_if #(
  parameter int IdWidth = 1
);
  logic               req_i;
  logic               we_i;
  logic [3:0]         be_i;
  logic [31:0]        addr_i;
  logic [31:0]        wdata_i;
  logic [IdWidth-1:0] aid_i;
  logic               gnt_o;
  logic               rvalid_o;
  logic [31:0]        rdata_o;
  logic               err_o;
  logic [IdWidth-1:0] rid_o;

  modport master (
    output req_i, we_i, be_i, addr_i, wdata_i, aid_i,
    input  gnt_o, rvalid_o, rdata_o, err_o, rid_o
  );

  modport slave (
    input  req_i, we_i, be_i, addr_i, wdata_i, aid_i,
    output gnt_o, rvalid_o, rdata_o, err_o, rid_o
  );
endinterface

// File: rtl/croc_soc_ctrl_regs.sv
// SoC control register block of the croc SoC.
//
// Holds the core boot address, a software fetch-enable bit and the core
// status / exit-code mailbox, all reachable over the OBI subordinate bus.
//
// Ports:
//   clk_i       : system clock
//   rst_ni      : asynchronous active-low reset
//   obi         : OBI subordinate bus (slave modport)
//   fetch_en_i  : fetch-enable pin from the pad
//   boot_addr_o : core boot address (BOOTADDR register)
//   fetch_en_o  : core fetch enable (pin OR FETCHEN bit 0)
//   status_o    : chip status pin, high while CORESTATUS is nonzero
//
// Register map (offset = addr_i[3:0], word access only):
//   0x0 BOOTADDR   32-bit RW
//   0x4 FETCHEN    bit 0 RW, upper bits read as zero
//   0x8 CORESTATUS 32-bit RW
//   0xC unmapped, responds with err_o
module croc_soc_ctrl_regs #(
  parameter logic [31:0] BootAddrDefault = 32'h1000_0000,
  parameter int          IdWidth         = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  croc_soc_ctrl_regs_if.slave  obi,
  input  logic                 fetch_en_i,
  output logic [31:0]          boot_addr_o,
  output logic                 fetch_en_o,
  output logic                 status_o
);

  localparam logic [1:0] OffBootAddr   = 2'd0;
  localparam logic [1:0] OffFetchEn    = 2'd1;
  localparam logic [1:0] OffCoreStatus = 2'd2;

  logic [31:0]        boot_addr_q,   boot_addr_d;
  logic               fetch_en_q,    fetch_en_d;
  logic [31:0]        core_status_q, core_status_d;
  logic               rvalid_q,      rvalid_d;
  logic [31:0]        rdata_q,       rdata_d;
  logic               err_q,         err_d;
  logic [IdWidth-1:0] rid_q,         rid_d;

  // Only addr_i[3:2] selects a register; the rest of the address is ignored.
  logic unused_addr;
  assign unused_addr = ^{obi.addr_i[31:4], obi.addr_i[1:0]};

  // Byte-lane merge: lanes with a clear enable keep their old contents.
  function automatic logic [31:0] merge_lanes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int k = 0; k < 4; k++) begin
      if (be[k]) res[8*k +: 8] = new_val[8*k +: 8];
    end
    return res;
  endfunction

  // Request decode. The response is fully computed here and registered, so
  // rdata/err/rid are naturally zero in any cycle without a response.
  always_comb begin
    boot_addr_d   = boot_addr_q;
    fetch_en_d    = fetch_en_q;
    core_status_d = core_status_q;
    rvalid_d      = obi.req_i;
    rdata_d       = 32'h0;
    err_d         = 1'b0;
    rid_d         = obi.req_i ? obi.aid_i : '0;

    if (obi.req_i) begin
      unique case (obi.addr_i[3:2])
        OffBootAddr: begin
          if (obi.we_i) boot_addr_d = merge_lanes(boot_addr_q, obi.wdata_i, obi.be_i);
          else          rdata_d     = boot_addr_q;
        end
        OffFetchEn: begin
          // Only bit 0 is stored, so only lane 0 matters.
          if (obi.we_i) begin
            if (obi.be_i[0]) fetch_en_d = obi.wdata_i[0];
          end else begin
            rdata_d = {31'b0, fetch_en_q};
          end
        end
        OffCoreStatus: begin
          if (obi.we_i) core_status_d = merge_lanes(core_status_q, obi.wdata_i, obi.be_i);
          else          rdata_d       = core_status_q;
        end
        default: begin
          err_d = 1'b1;
        end
      endcase
    end
  end

  // State and response registers; reset drops any pending response.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      boot_addr_q   <= BootAddrDefault;
      fetch_en_q    <= 1'b0;
      core_status_q <= 32'h0;
      rvalid_q      <= 1'b0;
      rdata_q       <= 32'h0;
      err_q         <= 1'b0;
      rid_q         <= '0;
    end else begin
      boot_addr_q   <= boot_addr_d;
      fetch_en_q    <= fetch_en_d;
      core_status_q <= core_status_d;
      rvalid_q      <= rvalid_d;
      rdata_q       <= rdata_d;
      err_q         <= err_d;
      rid_q         <= rid_d;
    end
  end

  // No back-pressure: every request is accepted in the cycle it appears.
  assign obi.gnt_o    = 1'b1;
  assign obi.rvalid_o = rvalid_q;
  assign obi.rdata_o  = rdata_q;
  assign obi.err_o    = err_q;
  assign obi.rid_o    = rid_q;

  // The pad pin can start the core without any software write.
  assign boot_addr_o = boot_addr_q;
  assign fetch_en_o  = fetch_en_i | fetch_en_q;
  assign status_o    = |core_status_q;

endmodule

// File: tb/tb_croc_soc_ctrl_regs.sv
// Self-checking bench for croc_soc_ctrl_regs: a register-array model is
// compared against the DUT every falling edge, and directed transactions
// are checked against hand-computed literal values.
module tb_croc_soc_ctrl_regs;

  localparam logic [31:0] BootDef = 32'h1000_0000;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        fetch_en_i = 1'b0;
  logic [31:0] boot_addr_o;
  logic        fetch_en_o;
  logic        status_o;

  int compared   = 0;
  int mismatched = 0;
  bit started    = 1'b0;

  croc_soc_ctrl_regs_if #(.IdWidth(1)) obi ();

  croc_soc_ctrl_regs #(
    .BootAddrDefault(BootDef),
    .IdWidth        (1)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .obi        (obi),
    .fetch_en_i (fetch_en_i),
    .boot_addr_o(boot_addr_o),
    .fetch_en_o (fetch_en_o),
    .status_o   (status_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: three registers indexed by word offset, plus the expected response.
  logic [31:0] m_regs [3];
  logic        m_rvalid;
  logic [31:0] m_rdata;
  logic        m_err;
  logic        m_rid;

  always @(posedge clk_i or negedge rst_ni) begin : model
    logic [31:0] nxt [3];
    logic [1:0]  idx;
    logic [31:0] rd;
    if (!rst_ni) begin
      m_regs[0] <= BootDef;
      m_regs[1] <= 32'h0;
      m_regs[2] <= 32'h0;
      m_rvalid  <= 1'b0;
      m_rdata   <= 32'h0;
      m_err     <= 1'b0;
      m_rid     <= 1'b0;
    end else begin
      nxt = m_regs;
      idx = obi.addr_i[3:2];
      rd  = 32'h0;
      if (obi.req_i && idx != 2'd3) begin
        if (obi.we_i) begin
          for (int k = 0; k < 4; k++)
            if (obi.be_i[k]) nxt[idx][8*k +: 8] = obi.wdata_i[8*k +: 8];
          nxt[1] = nxt[1] & 32'h1;
        end else begin
          rd = m_regs[idx];
        end
      end
      m_regs    <= nxt;
      m_rvalid  <= obi.req_i;
      m_rdata   <= rd;
      m_err     <= obi.req_i && idx == 2'd3;
      m_rid     <= obi.req_i ? obi.aid_i[0] : 1'b0;
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk_i) begin
    if (started) begin
      checkOutput("cyc_gnt",       {31'b0, obi.gnt_o},    32'h1);
      checkOutput("cyc_rvalid",    {31'b0, obi.rvalid_o}, {31'b0, m_rvalid});
      checkOutput("cyc_rdata",     obi.rdata_o,           m_rdata);
      checkOutput("cyc_err",       {31'b0, obi.err_o},    {31'b0, m_err});
      checkOutput("cyc_rid",       {31'b0, obi.rid_o},    {31'b0, m_rid});
      checkOutput("cyc_boot_addr", boot_addr_o,           m_regs[0]);
      checkOutput("cyc_fetch_en",  {31'b0, fetch_en_o},   {31'b0, fetch_en_i | m_regs[1][0]});
      checkOutput("cyc_status",    {31'b0, status_o},     {31'b0, m_regs[2] != 32'h0});
    end
  end

  // One accepted transaction; returns 1 time unit after the accept edge,
  // which is the response cycle.
  task automatic applyStimulus(input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] be,
                               input logic aid);
    obi.req_i   = 1'b1;
    obi.we_i    = we;
    obi.addr_i  = addr;
    obi.wdata_i = wdata;
    obi.be_i    = be;
    obi.aid_i   = aid;
    @(posedge clk_i);
    #1;
    obi.req_i   = 1'b0;
    obi.we_i    = 1'b0;
    obi.addr_i  = 32'h0;
    obi.wdata_i = 32'h0;
    obi.be_i    = 4'h0;
    obi.aid_i   = 1'b0;
  endtask

  task automatic readCheck(input logic [31:0] addr, input logic [31:0] exp, input string name);
    applyStimulus(1'b0, addr, 32'h0, 4'h0, 1'b0);
    checkOutput({name, "_rvalid"}, {31'b0, obi.rvalid_o}, 32'h1);
    checkOutput({name, "_rdata"},  obi.rdata_o,           exp);
    checkOutput({name, "_err"},    {31'b0, obi.err_o},    32'h0);
  endtask

  initial begin
    obi.req_i   = 1'b0;
    obi.we_i    = 1'b0;
    obi.addr_i  = 32'h0;
    obi.wdata_i = 32'h0;
    obi.be_i    = 4'h0;
    obi.aid_i   = 1'b0;
    @(posedge clk_i);
    started = 1'b1;
    repeat (2) @(posedge clk_i);
    #3 rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    // Reset state
    checkOutput("rst_boot",     boot_addr_o,           BootDef);
    checkOutput("rst_fetch_en", {31'b0, fetch_en_o},   32'h0);
    checkOutput("rst_status",   {31'b0, status_o},     32'h0);
    checkOutput("rst_rvalid",   {31'b0, obi.rvalid_o}, 32'h0);
    readCheck(32'h0, BootDef, "rd_boot_rst");
    readCheck(32'h4, 32'h0,   "rd_fen_rst");
    readCheck(32'h8, 32'h0,   "rd_cst_rst");

    // BOOTADDR full and partial writes
    applyStimulus(1'b1, 32'h0, 32'h1234_5678, 4'hF, 1'b0);
    checkOutput("wr_boot_rdata", obi.rdata_o, 32'h0);
    checkOutput("wr_boot_out",   boot_addr_o, 32'h1234_5678);
    readCheck(32'h0, 32'h1234_5678, "rd_boot_full");
    applyStimulus(1'b1, 32'h0, 32'hAABB_CCDD, 4'b0101, 1'b0);
    readCheck(32'h0, 32'h12BB_56DD, "rd_boot_lanes");
    checkOutput("boot_lanes_out", boot_addr_o, 32'h12BB_56DD);

    // Fetch enable from the pin and from the register
    fetch_en_i = 1'b1;
    #1;
    checkOutput("fen_pin", {31'b0, fetch_en_o}, 32'h1);
    fetch_en_i = 1'b0;
    #1;
    checkOutput("fen_pin_off", {31'b0, fetch_en_o}, 32'h0);
    applyStimulus(1'b1, 32'h4, 32'hFFFF_FFFF, 4'hF, 1'b0);
    checkOutput("fen_reg", {31'b0, fetch_en_o}, 32'h1);
    readCheck(32'h4, 32'h0000_0001, "rd_fen");

    // CORESTATUS mailbox drives the status pin
    applyStimulus(1'b1, 32'h8, 32'h0000_0001, 4'hF, 1'b0);
    checkOutput("status_set", {31'b0, status_o}, 32'h1);
    readCheck(32'h8, 32'h1, "rd_cst");
    applyStimulus(1'b1, 32'h8, 32'h0, 4'hF, 1'b0);
    checkOutput("status_clr", {31'b0, status_o}, 32'h0);

    // Unmapped offset, with address low bits set to show they are ignored
    applyStimulus(1'b1, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 4'hF, 1'b1);
    checkOutput("unm_wr_rvalid", {31'b0, obi.rvalid_o}, 32'h1);
    checkOutput("unm_wr_err",    {31'b0, obi.err_o},    32'h1);
    checkOutput("unm_wr_rdata",  obi.rdata_o,           32'h0);
    checkOutput("unm_wr_rid",    {31'b0, obi.rid_o},    32'h1);
    applyStimulus(1'b0, 32'h0000_000C, 32'h0, 4'h0, 1'b1);
    checkOutput("unm_rd_err",   {31'b0, obi.err_o}, 32'h1);
    checkOutput("unm_rd_rdata", obi.rdata_o,        32'h0);
    checkOutput("unm_rd_rid",   {31'b0, obi.rid_o}, 32'h1);
    readCheck(32'h0, 32'h12BB_56DD, "rd_boot_after_unm");
    readCheck(32'h8, 32'h0,         "rd_cst_after_unm");

    // Back-to-back reads, one response per cycle
    readCheck(32'h0, 32'h12BB_56DD, "b2b_boot");
    readCheck(32'h4, 32'h1,         "b2b_fen");
    readCheck(32'h8, 32'h0,         "b2b_cst");

    // Reset in the middle of a stream of reads
    obi.req_i  = 1'b1;
    obi.addr_i = 32'h0;
    @(posedge clk_i);
    #2;
    checkOutput("pre_rst_rvalid", {31'b0, obi.rvalid_o}, 32'h1);
    rst_ni = 1'b0;
    #1;
    checkOutput("mid_rst_rvalid", {31'b0, obi.rvalid_o}, 32'h0);
    checkOutput("mid_rst_boot",   boot_addr_o,           BootDef);
    checkOutput("mid_rst_fen",    {31'b0, fetch_en_o},   32'h0);
    obi.req_i = 1'b0;
    @(negedge clk_i);
    #2 rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    readCheck(32'h0, BootDef, "rd_boot_post_rst");
    readCheck(32'h4, 32'h0,   "rd_fen_post_rst");

    repeat (2) @(posedge clk_i);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
